// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus datapath: width, ALU opcodes, bus sources.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package datapath_pkg;

   localparam int WIDTH = 32;

   // ALU opcodes presented on the IRout strobe lines
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   // Bus sources listed from highest to lowest priority; the encoding is the
   // bit position of each out-select in the packed select vector.
   typedef enum logic [4:0] {
      SRC_MDR, SRC_ZLO, SRC_ZHI, SRC_HI, SRC_LO, SRC_PC, SRC_INPORT, SRC_C,
      SRC_R0, SRC_R1, SRC_R2, SRC_R3, SRC_R4, SRC_R5, SRC_R6, SRC_R7,
      SRC_R8, SRC_R9, SRC_R10, SRC_R11, SRC_R12, SRC_R13, SRC_R14, SRC_R15,
      SRC_NONE
   } bus_src_e;

   localparam int NUM_SRC = 24;

   // Immediate C operand: sign-extended low 19 bits of the instruction word
   function automatic logic [WIDTH-1:0] sext_c(input logic [18:0] imm);
      return {{(WIDTH-19){imm[18]}}, imm};
   endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational 32x32->64 ALU: A from Y, B from the bus, result goes to Z.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
module datapath_alu
   import datapath_pkg::*;
(
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   input  logic [4:0]         i_op,
   input  logic               i_inc_pc,
   output logic [2*WIDTH-1:0] o_res
);

   logic [4:0]           w_sh;
   logic [5:0]           w_sh_inv;
   logic signed [63:0]   w_prod;
   logic                 w_div_zero;
   logic                 w_div_ovf;
   logic [WIDTH-1:0]     w_div_b;
   logic [WIDTH-1:0]     w_quo;
   logic [WIDTH-1:0]     w_rem;
   logic [WIDTH-1:0]     w_lo;
   logic [WIDTH-1:0]     w_hi;

   assign w_sh     = i_b[4:0];
   assign w_sh_inv = 6'd32 - {1'b0, w_sh};
   assign w_prod   = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});

   // Divisor is forced to 1 for the two special cases so the divider never
   // sees a zero divisor or the INT_MIN / -1 overflow; those are patched below.
   assign w_div_zero = (i_b == '0);
   assign w_div_ovf  = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
   assign w_div_b    = (w_div_zero || w_div_ovf) ? 32'd1 : i_b;
   assign w_quo      = $signed(i_a) / $signed(w_div_b);
   assign w_rem      = $signed(i_a) % $signed(w_div_b);

   // Opcode decode; single-word results leave the high half at zero
   always_comb begin
      w_lo = '0;
      w_hi = '0;
      if (i_inc_pc) begin
         w_lo = i_b + 32'd1;
      end else begin
         case (i_op)
            OP_ADD:  w_lo = i_a + i_b;
            OP_SUB:  w_lo = i_a - i_b;
            OP_SHR:  w_lo = i_a >> w_sh;
            OP_SHRA: w_lo = $signed(i_a) >>> w_sh;
            OP_SHL:  w_lo = i_a << w_sh;
            OP_ROR:  w_lo = (i_a >> w_sh) | (i_a << w_sh_inv);
            OP_ROL:  w_lo = (i_a << w_sh) | (i_a >> w_sh_inv);
            OP_AND:  w_lo = i_a & i_b;
            OP_OR:   w_lo = i_a | i_b;
            OP_MUL:  {w_hi, w_lo} = w_prod;
            OP_DIV: begin
               if (w_div_zero) begin
                  w_lo = 32'hFFFF_FFFF;
                  w_hi = i_a;
               end else if (w_div_ovf) begin
                  w_lo = i_a;
                  w_hi = '0;
               end else begin
                  w_lo = w_quo;
                  w_hi = w_rem;
               end
            end
            OP_NEG:  w_lo = 32'd0 - i_b;
            OP_NOT:  w_lo = ~i_b;
            default: w_lo = '0;
         endcase
      end
   end

   assign o_res = {w_hi, w_lo};

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, PC/IR/MAR/MDR/HI/LO/Y/Z around one shared bus and ALU.
// Latency: source drives the bus combinationally; destination loads on the next rising edge.
// Backpressure: none; strobes are obeyed every cycle, one bus transfer per clock.
module datapath
   import datapath_pkg::*;
(
   input  logic             clk,
   input  logic             Clear,
   input  logic             Read,
   input  logic [WIDTH-1:0] Mdatain,
   input  logic [4:0]       IRout,
   input  logic             IncPC,
   input  logic             PCin,
   input  logic             IRin,
   input  logic             Yin,
   input  logic             Zin,
   input  logic             MARin,
   input  logic             MDRin,
   input  logic             HIin,
   input  logic             LOin,
   input  logic             R0in,
   input  logic             R1in,
   input  logic             R2in,
   input  logic             R3in,
   input  logic             R4in,
   input  logic             R5in,
   input  logic             R6in,
   input  logic             R7in,
   input  logic             PCout,
   input  logic             MDRout,
   input  logic             HIout,
   input  logic             LOout,
   input  logic             Zhiout,
   input  logic             Zlowout,
   input  logic             InPortout,
   input  logic             Cout,
   input  logic             R0out,
   input  logic             R1out,
   input  logic             R2out,
   input  logic             R3out,
   input  logic             R4out,
   input  logic             R5out,
   input  logic             R6out,
   input  logic             R7out,
   input  logic             R8out,
   input  logic             R9out,
   input  logic             R10out,
   input  logic             R11out,
   input  logic             R12out,
   input  logic             R13out,
   input  logic             R14out,
   input  logic             R15out,
   output logic [WIDTH-1:0] Busout,
   output logic [WIDTH-1:0] R0_out
);

   logic [WIDTH-1:0]   r_pc;
   logic [WIDTH-1:0]   r_ir;
   logic [WIDTH-1:0]   r_mar;
   logic [WIDTH-1:0]   r_mdr;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_y;
   logic [WIDTH-1:0]   r_zhi;
   logic [WIDTH-1:0]   r_zlo;
   logic [WIDTH-1:0]   r_gpr [0:7];

   logic [NUM_SRC-1:0] w_sel;
   logic [4:0]         w_src;
   logic [WIDTH-1:0]   w_bus;
   logic [7:0]         w_gpr_in;
   logic [2*WIDTH-1:0] w_alu_res;

   // Select vector bit i corresponds to bus_src_e value i (bit 0 = highest priority)
   assign w_sel = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out,
                   Cout, InPortout, PCout, LOout, HIout, Zhiout, Zlowout, MDRout};

   assign w_gpr_in = {R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

   // Priority encoder: scan from lowest priority upward so the highest active select wins
   always_comb begin
      w_src = SRC_NONE;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_sel[i]) w_src = 5'(i);
      end
   end

   // Bus multiplexer; InPort, R8..R15 and "nothing selected" all read as zero
   always_comb begin
      w_bus = '0;
      case (w_src)
         SRC_MDR: w_bus = r_mdr;
         SRC_ZLO: w_bus = r_zlo;
         SRC_ZHI: w_bus = r_zhi;
         SRC_HI:  w_bus = r_hi;
         SRC_LO:  w_bus = r_lo;
         SRC_PC:  w_bus = r_pc;
         SRC_C:   w_bus = sext_c(r_ir[18:0]);
         SRC_R0:  w_bus = r_gpr[0];
         SRC_R1:  w_bus = r_gpr[1];
         SRC_R2:  w_bus = r_gpr[2];
         SRC_R3:  w_bus = r_gpr[3];
         SRC_R4:  w_bus = r_gpr[4];
         SRC_R5:  w_bus = r_gpr[5];
         SRC_R6:  w_bus = r_gpr[6];
         SRC_R7:  w_bus = r_gpr[7];
         default: w_bus = '0;
      endcase
   end

   datapath_alu u_alu (
      .i_a      (r_y),
      .i_b      (w_bus),
      .i_op     (IRout),
      .i_inc_pc (IncPC),
      .o_res    (w_alu_res)
   );

   // Special-purpose registers: each captures the bus when enabled; MDR may take memory data
   always_ff @(posedge clk or negedge Clear) begin
      if (!Clear) begin
         r_pc  <= '0;
         r_ir  <= '0;
         r_mar <= '0;
         r_mdr <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_y   <= '0;
      end else begin
         if (PCin)  r_pc  <= w_bus;
         if (IRin)  r_ir  <= w_bus;
         if (MARin) r_mar <= w_bus;
         if (MDRin) r_mdr <= Read ? Mdatain : w_bus;
         if (HIin)  r_hi  <= w_bus;
         if (LOin)  r_lo  <= w_bus;
         if (Yin)   r_y   <= w_bus;
      end
   end

   // Z captures the full 64-bit ALU result
   always_ff @(posedge clk or negedge Clear) begin
      if (!Clear) begin
         r_zhi <= '0;
         r_zlo <= '0;
      end else if (Zin) begin
         r_zhi <= w_alu_res[2*WIDTH-1:WIDTH];
         r_zlo <= w_alu_res[WIDTH-1:0];
      end
   end

   // Writable general registers R0..R7; R8..R15 have no storage and read as zero
   always_ff @(posedge clk or negedge Clear) begin
      if (!Clear) begin
         for (int i = 0; i < 8; i++) r_gpr[i] <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (w_gpr_in[i]) r_gpr[i] <= w_bus;
         end
      end
   end

   assign Busout = w_bus;
   assign R0_out = r_gpr[0];

endmodule

// File: tb/tb_datapath.sv
// Scoreboarded bench for the single-bus datapath with a behavioural reference model.
// Latency: expectations are pushed when strobes are driven, checked mid-cycle by the monitor.
// Backpressure: none; every driven cycle produces one expected bus/R0 observation.
module tb_datapath;

   logic        clk;
   logic        Clear;
   logic        Read;
   logic [31:0] Mdatain;
   logic [4:0]  IRout;
   logic        IncPC;
   logic [23:0] t_outs;
   logic [15:0] t_ins;
   logic [31:0] Busout;
   logic [31:0] R0_out;

   // out-select bit positions (priority order) and in-enable bit positions
   localparam int O_MDR = 0, O_ZLO = 1, O_ZHI = 2, O_HI = 3, O_LO = 4, O_PC = 5,
                  O_INPORT = 6, O_C = 7, O_R0 = 8;
   localparam int I_PC = 0, I_IR = 1, I_Y = 2, I_Z = 3, I_MAR = 4, I_MDR = 5,
                  I_HI = 6, I_LO = 7, I_R0 = 8;

   localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, MUL = 5'b01110, DIV = 5'b01111;

   datapath dut (
      .clk(clk), .Clear(Clear), .Read(Read), .Mdatain(Mdatain), .IRout(IRout), .IncPC(IncPC),
      .PCin(t_ins[0]), .IRin(t_ins[1]), .Yin(t_ins[2]), .Zin(t_ins[3]),
      .MARin(t_ins[4]), .MDRin(t_ins[5]), .HIin(t_ins[6]), .LOin(t_ins[7]),
      .R0in(t_ins[8]), .R1in(t_ins[9]), .R2in(t_ins[10]), .R3in(t_ins[11]),
      .R4in(t_ins[12]), .R5in(t_ins[13]), .R6in(t_ins[14]), .R7in(t_ins[15]),
      .MDRout(t_outs[0]), .Zlowout(t_outs[1]), .Zhiout(t_outs[2]), .HIout(t_outs[3]),
      .LOout(t_outs[4]), .PCout(t_outs[5]), .InPortout(t_outs[6]), .Cout(t_outs[7]),
      .R0out(t_outs[8]), .R1out(t_outs[9]), .R2out(t_outs[10]), .R3out(t_outs[11]),
      .R4out(t_outs[12]), .R5out(t_outs[13]), .R6out(t_outs[14]), .R7out(t_outs[15]),
      .R8out(t_outs[16]), .R9out(t_outs[17]), .R10out(t_outs[18]), .R11out(t_outs[19]),
      .R12out(t_outs[20]), .R13out(t_outs[21]), .R14out(t_outs[22]), .R15out(t_outs[23]),
      .Busout(Busout), .R0_out(R0_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model state ----------------
   logic [31:0] m_r [0:7];
   logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_zhi, m_zlo;

   typedef struct {
      logic [31:0] bus;
      logic [31:0] r0;
   } exp_t;
   exp_t sb[$];

   int   n_checks = 0;
   int   n_errors = 0;
   logic chk_vld  = 1'b0;

   function automatic void m_reset();
      for (int k = 0; k < 8; k++) m_r[k] = '0;
      m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_hi = '0;
      m_lo = '0; m_y = '0; m_zhi = '0; m_zlo = '0;
   endfunction

   // value a given source would place on the bus
   function automatic logic [31:0] m_src(int k);
      case (k)
         0: return m_mdr;
         1: return m_zlo;
         2: return m_zhi;
         3: return m_hi;
         4: return m_lo;
         5: return m_pc;
         6: return 32'd0;
         7: return {{13{m_ir[18]}}, m_ir[18:0]};
         default: return (k < 16) ? m_r[k-8] : 32'd0;
      endcase
   endfunction

   // behavioural ALU using 64-bit integer arithmetic
   function automatic logic [63:0] m_alu(logic [31:0] a, logic [31:0] b, logic [4:0] op, logic inc);
      longint      sa, sb_, q, r;
      logic [63:0] w, qq, rr;
      int          sh;
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      sh  = int'(b[4:0]);
      if (inc) return {32'd0, b + 32'd1};
      case (op)
         5'b00011: return {32'd0, a + b};
         5'b00100: return {32'd0, a - b};
         5'b00101: return {32'd0, a >> sh};
         5'b00110: begin w = 64'(sa >>> sh); return {32'd0, w[31:0]}; end
         5'b00111: return {32'd0, a << sh};
         5'b01000: begin w = {a, a} >> sh; return {32'd0, w[31:0]}; end
         5'b01001: begin w = {a, a} << sh; return {32'd0, w[63:32]}; end
         5'b01010: return {32'd0, a & b};
         5'b01011: return {32'd0, a | b};
         5'b01110: return 64'(sa * sb_);
         5'b01111: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb_;
            r = sa % sb_;
            qq = 64'(q);
            rr = 64'(r);
            return {rr[31:0], qq[31:0]};
         end
         5'b10001: return {32'd0, 32'd0 - b};
         5'b10010: return {32'd0, ~b};
         default:  return 64'd0;
      endcase
   endfunction

   function automatic logic [23:0] ob(int k);
      return 24'd1 << k;
   endfunction

   function automatic logic [15:0] ib(int k);
      return 16'd1 << k;
   endfunction

   // drive one transfer cycle, push the expected observation, advance the model
   task automatic drive(input logic [23:0] outs, input logic [15:0] ins, input logic rd,
                        input logic [31:0] md, input logic [4:0] op, input logic inc,
                        input logic has_want, input logic [31:0] want);
      logic [31:0] bus;
      logic [63:0] z;
      bit          found;
      exp_t        e;
      @(posedge clk);
      #1;
      Clear = 1'b1; t_outs = outs; t_ins = ins; Read = rd;
      Mdatain = md; IRout = op; IncPC = inc;
      bus = 32'd0;
      found = 1'b0;
      for (int k = 0; k < 24; k++) begin
         if (outs[k] && !found) begin
            bus = m_src(k);
            found = 1'b1;
         end
      end
      e.bus = has_want ? want : bus;
      e.r0  = m_r[0];
      sb.push_back(e);
      chk_vld = 1'b1;
      z = m_alu(m_y, bus, op, inc);
      if (ins[I_PC])  m_pc  = bus;
      if (ins[I_IR])  m_ir  = bus;
      if (ins[I_Y])   m_y   = bus;
      if (ins[I_Z])   {m_zhi, m_zlo} = z;
      if (ins[I_MAR]) m_mar = bus;
      if (ins[I_MDR]) m_mdr = rd ? md : bus;
      if (ins[I_HI])  m_hi  = bus;
      if (ins[I_LO])  m_lo  = bus;
      for (int k = 0; k < 8; k++) if (ins[I_R0+k]) m_r[k] = bus;
   endtask

   // assert Clear asynchronously mid-cycle with arbitrary strobes active
   task automatic reset_pulse();
      exp_t e;
      @(posedge clk);
      #3;
      t_outs = 24'($urandom); t_ins = 16'($urandom); Read = 1'($urandom);
      Mdatain = $urandom; IRout = 5'($urandom); IncPC = 1'($urandom);
      Clear = 1'b0;
      m_reset();
      e.bus = 32'd0;
      e.r0  = 32'd0;
      sb.push_back(e);
      chk_vld = 1'b1;
   endtask

   // monitor: compare the DUT against the oldest expectation each checked cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (chk_vld) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_errors++;
               $display("FAIL scoreboard_underflow: got empty queue, required an entry");
            end else begin
               e = sb.pop_front();
               if (Busout !== e.bus) begin
                  n_errors++;
                  $display("FAIL bus @%0t: got %h required %h", $time, Busout, e.bus);
               end
               n_checks++;
               if (R0_out !== e.r0) begin
                  n_errors++;
                  $display("FAIL r0 @%0t: got %h required %h", $time, R0_out, e.r0);
               end
            end
         end
      end
   end

   logic [4:0] ops [14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                            5'b01010, 5'b01011, 5'b01110, 5'b01111, 5'b10001, 5'b10010, 5'b00000};

   task automatic random_cycles(int n);
      logic [23:0] outs;
      logic [15:0] ins;
      logic [31:0] md;
      logic [4:0]  op;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 1) == 0) outs = ob($urandom_range(0, 23));
         else outs = 24'($urandom & $urandom);
         ins = 16'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 2) == 0) ins[I_Z] = 1'b1;
         if ($urandom_range(0, 3) == 0) ins[I_Y] = 1'b1;
         md = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
         op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : ops[$urandom_range(0, 13)];
         drive(outs, ins, 1'($urandom), md, op, ($urandom_range(0, 7) == 0), 1'b0, 32'd0);
      end
   endtask

   initial begin
      Clear = 1'b0; t_outs = '0; t_ins = '0; Read = 1'b0;
      Mdatain = '0; IRout = '0; IncPC = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);

      // reset with loads asserted, then registers still zero after release
      reset_pulse();
      drive(ob(O_MDR), 16'd0, 0, 0, 0, 0, 1, 32'd0);
      drive(ob(O_R0) | ob(O_ZLO) | ob(O_PC), 16'd0, 0, 0, 0, 0, 1, 32'd0);

      // MDR -> R1 and R0
      drive(24'd0, ib(I_MDR), 1, 32'd25, 0, 0, 1, 32'd0);
      drive(ob(O_MDR), ib(I_R0+1), 0, 0, 0, 0, 1, 32'd25);
      drive(ob(O_MDR), ib(I_R0), 0, 0, 0, 0, 1, 32'd25);
      drive(ob(O_R0+1), 16'd0, 0, 0, 0, 0, 1, 32'd25);

      // 30 / 25
      drive(24'd0, ib(I_MDR), 1, 32'd30, 0, 0, 1, 32'd0);
      drive(ob(O_MDR), ib(I_Y), 0, 0, 0, 0, 1, 32'd30);
      drive(ob(O_R0+1), ib(I_Z), 0, 0, DIV, 0, 1, 32'd25);
      drive(ob(O_ZLO), 16'd0, 0, 0, 0, 0, 1, 32'd1);
      drive(ob(O_ZHI), 16'd0, 0, 0, 0, 0, 1, 32'd5);

      // -7 / 2 and -7 * 2
      drive(24'd0, ib(I_MDR), 1, 32'hFFFF_FFF9, 0, 0, 1, 32'd0);
      drive(ob(O_MDR), ib(I_Y), 0, 0, 0, 0, 1, 32'hFFFF_FFF9);
      drive(24'd0, ib(I_MDR), 1, 32'd2, 0, 0, 1, 32'd0);
      drive(ob(O_MDR), ib(I_Z), 0, 0, DIV, 0, 1, 32'd2);
      drive(ob(O_ZLO), 16'd0, 0, 0, 0, 0, 1, 32'hFFFF_FFFD);
      drive(ob(O_ZHI), 16'd0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
      drive(ob(O_MDR), ib(I_Z), 0, 0, MUL, 0, 1, 32'd2);
      drive(ob(O_ZLO), 16'd0, 0, 0, 0, 0, 1, 32'hFFFF_FFF2);
      drive(ob(O_ZHI), 16'd0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);

      // 9 / 0
      drive(24'd0, ib(I_MDR), 1, 32'd9, 0, 0, 1, 32'd0);
      drive(ob(O_MDR), ib(I_Y), 0, 0, 0, 0, 1, 32'd9);
      drive(ob(O_INPORT), ib(I_Z), 0, 0, DIV, 0, 1, 32'd0);
      drive(ob(O_ZLO), 16'd0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
      drive(ob(O_ZHI), 16'd0, 0, 0, 0, 0, 1, 32'd9);

      // PC increment overrides the opcode
      drive(24'd0, ib(I_MDR), 1, 32'd4, 0, 0, 1, 32'd0);
      drive(ob(O_MDR), ib(I_PC), 0, 0, 0, 0, 1, 32'd4);
      drive(ob(O_PC), ib(I_Z), 0, 0, MUL, 1, 1, 32'd4);
      drive(ob(O_ZLO), ib(I_PC), 0, 0, 0, 0, 1, 32'd5);
      drive(ob(O_PC), 16'd0, 0, 0, 0, 0, 1, 32'd5);
      drive(ob(O_R0+8) | ob(O_R0+15), 16'd0, 0, 0, 0, 0, 1, 32'd0);

      // priority and C source
      drive(ob(O_MDR) | ob(O_ZLO) | ob(O_PC), 16'd0, 0, 0, 0, 0, 1, 32'd4);
      drive(ob(O_ZLO) | ob(O_PC) | ob(O_R0), 16'd0, 0, 0, 0, 0, 1, 32'd5);
      drive(24'd0, ib(I_MDR), 1, 32'h0004_0001, 0, 0, 1, 32'd0);
      drive(ob(O_MDR), ib(I_IR), 0, 0, 0, 0, 1, 32'h0004_0001);
      drive(ob(O_C) | ob(O_R0), 16'd0, 0, 0, 0, 0, 1, 32'hFFFC_0001);

      // randomized traffic with a mid-run reset
      random_cycles(300);
      reset_pulse();
      random_cycles(300);

      @(posedge clk);
      #1;
      chk_vld = 1'b0;
      repeat (2) @(posedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
